// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with combinational sum/carry outputs and a
// one-stage registered copy of the result (sum, carry, signed overflow, valid).
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sum;
  logic             w_carryOut;
  logic             w_carryIntoMsb;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sumQ;
  logic             r_carryQ;
  logic             r_ovfQ;
  logic             r_validQ;

  // Bit-serial ripple; also remembers the carry entering the MSB for overflow.
  always_comb begin
    logic carry;
    carry          = cin;
    w_carryIntoMsb = cin;
    w_sum          = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_carryIntoMsb = carry;
      w_sum[i]       = a[i] ^ b[i] ^ carry;
      carry          = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    w_carryOut = carry;
  end

  // Signed overflow: carry into the MSB disagrees with the carry out of it.
  assign w_ovf = w_carryOut ^ w_carryIntoMsb;

  assign s    = w_sum;
  assign cout = w_carryOut;

  // Capture the result on accepted inputs; the valid flag tracks in_valid each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sumQ   <= '0;
      r_carryQ <= 1'b0;
      r_ovfQ   <= 1'b0;
      r_validQ <= 1'b0;
    end else begin
      r_validQ <= in_valid;
      if (in_valid) begin
        r_sumQ   <= w_sum;
        r_carryQ <= w_carryOut;
        r_ovfQ   <= w_ovf;
      end
    end
  end

  assign s_q       = r_sumQ;
  assign cout_q    = r_carryQ;
  assign ovf_q     = r_ovfQ;
  assign out_valid = r_validQ;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a 1-bit and an 8-bit instance share clock
// and reset; expected registered results are queued when issued and popped by
// monitors whenever the DUT raises out_valid.
module tb_full_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } result_t;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1, iv1;
  logic       s1, cout1, sq1, coutq1, ovfq1, ov1;

  logic [7:0] a8, b8;
  logic       cin8, iv8;
  logic [7:0] s8, sq8;
  logic       cout8, coutq8, ovfq8, ov8;

  result_t    queue1[$];
  result_t    queue8[$];

  int         checks;
  int         errors;
  int         streamValidCycles;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .in_valid(iv1),
    .s_q(sq1), .cout_q(coutq1), .ovf_q(ovfq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .in_valid(iv8),
    .s_q(sq8), .cout_q(coutq8), .ovf_q(ovfq8), .out_valid(ov8)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive the 8-bit instance just after a falling edge; queue the expected result.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic iv, input result_t exp);
    @(negedge clk);
    #1;
    a8 = a; b8 = b; cin8 = c; iv8 = iv;
    if (iv) queue8.push_back(exp);
  endtask

  task automatic applyStimulus1(input logic a, input logic b, input logic c,
                                input logic iv, input result_t exp);
    @(negedge clk);
    #1;
    a1 = a; b1 = b; cin1 = c; iv1 = iv;
    if (iv) queue1.push_back(exp);
  endtask

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    result_t e;
    if (rst_n && ov1) begin
      if (queue1.size() == 0) begin
        checkOutput("w1_unexpected_valid", 64'(ov1), 64'(0));
      end else begin
        e = queue1.pop_front();
        checkOutput("w1_s_q",    64'(sq1),    64'(e.s[0]));
        checkOutput("w1_cout_q", 64'(coutq1), 64'(e.cout));
        checkOutput("w1_ovf_q",  64'(ovfq1),  64'(e.ovf));
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    result_t e;
    if (rst_n && ov8) begin
      streamValidCycles++;
      if (queue8.size() == 0) begin
        checkOutput("w8_unexpected_valid", 64'(ov8), 64'(0));
      end else begin
        e = queue8.pop_front();
        checkOutput("w8_s_q",    64'(sq8),    64'(e.s));
        checkOutput("w8_cout_q", 64'(coutq8), 64'(e.cout));
        checkOutput("w8_ovf_q",  64'(ovfq8),  64'(e.ovf));
      end
    end
  end

  // Directed test sequence.
  initial begin
    logic [1:0] sweepExp[8];
    result_t    stream[4];
    logic [7:0] streamA[4];
    logic [7:0] streamB[4];
    logic       streamC[4];

    checks = 0; errors = 0; streamValidCycles = 0;
    rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;

    // (s,cout) for abc = 000..111
    sweepExp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    // Exhaustive 1-bit sweep while reset is held.
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0];
      #1;
      checkOutput("w1_comb_s",    64'(s1),    64'(sweepExp[i][1]));
      checkOutput("w1_comb_cout", 64'(cout1), 64'(sweepExp[i][0]));
      #9;
    end
    checkOutput("rst_w1_out_valid", 64'(ov1),    64'(0));
    checkOutput("rst_w1_s_q",       64'(sq1),    64'(0));
    checkOutput("rst_w8_out_valid", 64'(ov8),    64'(0));
    checkOutput("rst_w8_s_q",       64'(sq8),    64'(0));
    checkOutput("rst_w8_cout_q",    64'(coutq8), 64'(0));
    checkOutput("rst_w8_ovf_q",     64'(ovfq8),  64'(0));

    @(negedge clk);
    rst_n = 1'b1;

    // 1-bit: 1+1+0 -> s=0 cout=1, ovf = cout^cin = 1.
    applyStimulus1(1'b1, 1'b1, 1'b0, 1'b1, '{s: 8'h00, cout: 1'b1, ovf: 1'b1});
    #1;
    checkOutput("w1_comb_s_11", 64'(s1),    64'(0));
    checkOutput("w1_comb_c_11", 64'(cout1), 64'(1));
    applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // 8-bit carry-out and overflow boundaries.
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, '{s: 8'h00, cout: 1'b1, ovf: 1'b0});
    #1;
    checkOutput("w8_comb_s_ff01",    64'(s8),    64'(8'h00));
    checkOutput("w8_comb_cout_ff01", 64'(cout8), 64'(1));
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b1, '{s: 8'h80, cout: 1'b0, ovf: 1'b1});
    #1;
    checkOutput("w8_comb_s_7f01",    64'(s8),    64'(8'h80));
    checkOutput("w8_comb_cout_7f01", 64'(cout8), 64'(0));
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1, '{s: 8'hFF, cout: 1'b1, ovf: 1'b0});
    #1;
    checkOutput("w8_comb_s_ffff1",    64'(s8),    64'(8'hFF));
    checkOutput("w8_comb_cout_ffff1", 64'(cout8), 64'(1));

    // Hold: in_valid low for 3 cycles with random operands.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'($urandom_range(255)), 8'($urandom_range(255)),
                    1'($urandom_range(1)), 1'b0, '0);
      @(posedge clk);
      #1;
      checkOutput("hold_s_q",       64'(sq8),    64'(8'hFF));
      checkOutput("hold_cout_q",    64'(coutq8), 64'(1));
      checkOutput("hold_out_valid", 64'(ov8),    64'(0));
    end

    // Streaming: four back-to-back accepted inputs.
    streamA = '{8'h12, 8'h80, 8'h55, 8'h40};
    streamB = '{8'h34, 8'h80, 8'hAA, 8'h40};
    streamC = '{1'b0,  1'b0,  1'b1,  1'b0};
    stream  = '{'{s: 8'h46, cout: 1'b0, ovf: 1'b0},
                '{s: 8'h00, cout: 1'b1, ovf: 1'b1},
                '{s: 8'h00, cout: 1'b1, ovf: 1'b0},
                '{s: 8'h80, cout: 1'b0, ovf: 1'b1}};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(streamA[i], streamB[i], streamC[i], 1'b1, stream[i]);
      if (i == 0) streamValidCycles = 0;
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, '0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, '0);
    checkOutput("stream_valid_cycles", 64'(streamValidCycles), 64'(4));

    // Mid-stream asynchronous reset.
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, '{s: 8'h46, cout: 1'b0, ovf: 1'b0});
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b1, '{s: 8'h02, cout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #2;
    checkOutput("pre_rst_out_valid", 64'(ov8), 64'(1));
    rst_n = 1'b0;
    queue8.delete();
    #1;
    checkOutput("async_rst_out_valid", 64'(ov8),    64'(0));
    checkOutput("async_rst_s_q",       64'(sq8),    64'(0));
    checkOutput("async_rst_ovf_q",     64'(ovfq8),  64'(0));
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; iv8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("in_rst_out_valid", 64'(ov8),    64'(0));
    checkOutput("in_rst_cout_q",    64'(coutq8), 64'(0));
    checkOutput("in_rst_s_q",       64'(sq8),    64'(0));
    iv8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b1, '{s: 8'h10, cout: 1'b0, ovf: 1'b0});
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, '0);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, '0);

    checkOutput("queue1_drained", 64'(queue1.size()), 64'(0));
    checkOutput("queue8_drained", 64'(queue8.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterised ripple-carry full adder: sum = a + b + cin, with carry-out.
- Primary outputs s/cout are purely combinational, so a 1-bit instance is a drop-in textbook full adder for arithmetic datapaths.
- Adds a one-stage registered copy of the result with valid flag and signed-overflow flag for pipelined users.
- Single clock domain; asynchronous active-low reset affects only the registered stage.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, unsigned (two's complement for the ovf_q flag).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- s  output  WIDTH  combinational sum bits.
- cout  output  1  combinational carry-out from the MSB.
- in_valid  input  1  qualifies a/b/cin for capture into the registered stage.
- s_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- ovf_q  output  1  registered signed overflow.
- out_valid  output  1  s_q/cout_q/ovf_q hold a result captured on the previous edge.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path:
  - {cout, s} = a + b + cin, computed at WIDTH+1 bits; no truncation of the carry.
  - Built as a bit-serial ripple: per bit i, s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]), with c[0] = cin and cout = c[WIDTH].
  - Zero latency: s/cout follow any input change within the same delta/cycle.
  - Combinational path is independent of clk, rst_n and in_valid; it stays valid while reset is asserted.
- Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1 this reduces to cout ^ cin.
- Registered stage, on rising clk:
  - If in_valid=1: s_q<=s, cout_q<=cout, ovf_q<=ovf.
  - If in_valid=0: s_q/cout_q/ovf_q hold their previous values.
  - out_valid <= in_valid every cycle. Latency is exactly 1 cycle.
  - There is no back-pressure; a result is presented for one cycle per accepted input.
- Reset:
  - rst_n low asynchronously forces s_q=0, cout_q=0, ovf_q=0, out_valid=0, independent of clk.
  - Release is synchronised by the user; the first capture is on the first rising edge with rst_n high.
  - Reset mid-stream discards the in-flight result: out_valid=0 after reset, with no stale result re-emitted.
- Boundaries:
  - All-ones + all-ones + 1 gives s = all-ones, cout = 1.
  - All-zero inputs give s = 0, cout = 0.
  - Back-to-back in_valid cycles produce one result per cycle with no bubble.
- X/Z inputs are not handled specially.

Test Plan:
- WIDTH=1, exhaustive sweep of (a,b,cin) 000..111, 10 time units apart, rst_n held low: (s,cout) = 00,10,10,01,10,01,01,11 respectively. Combinational outputs must be correct despite reset.
- WIDTH=1, rst_n=1, in_valid=1 with a=1,b=1,cin=0: s=0,cout=1 immediately. On the next edge s_q=0, cout_q=1, out_valid=1, ovf_q=1 (cout^cin).
- WIDTH=8, a=0xFF,b=0x01,cin=0: s=0x00, cout=1, ovf_q=0 after one edge. Then a=0x7F,b=0x01,cin=0: s=0x80, cout=0, ovf_q=1.
- WIDTH=8, a=0xFF,b=0xFF,cin=1: s=0xFF, cout=1, ovf_q=0. Then in_valid=0 for 3 cycles with random a/b: s_q stays 0xFF, cout_q stays 1, out_valid=0.
- Streaming: 4 consecutive in_valid cycles with distinct operands; s_q/cout_q match each sum one cycle later, and out_valid stays high for 4 cycles.
- Reset mid-operation: assert rst_n=0 between edges while out_valid=1. s_q, cout_q, ovf_q and out_valid go to 0 immediately, without waiting for clk, and remain 0 until the first post-release capture edge.
